// File: rtl/seg_scan_capture.sv
// seg_scan_capture: rebuilds the four characters shown on a multiplexed active-low 7-segment display.
// Defining SEG_CAPTURE_FRAME_CNT_EN adds a 16-bit wrapping frame_count output.
module seg_scan_capture #(
    parameter int STABLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 65536
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  Anode_Activate,
    input  logic [6:0]  LED_out,
    output logic [19:0] frame_digits,
    output logic        frame_valid,
    output logic        frame_changed,
    output logic        timeout,
    output logic        err_anode,
    output logic        err_seg
`ifdef SEG_CAPTURE_FRAME_CNT_EN
    ,
    output logic [15:0] frame_count
`endif
);

    localparam int SW = $clog2(STABLE_CYCLES + 1);
    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [SW-1:0] STAB    = SW'(STABLE_CYCLES);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [4:0]    CODE_BLANK = 5'h10;
    localparam logic [4:0]    CODE_BAD   = 5'h1F;

    typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_EMIT} slot_state_e;

    logic [3:0]       s_an_q, s_an_d, p_an_q, p_an_d;
    logic [6:0]       s_seg_q, s_seg_d, p_seg_q, p_seg_d;
    logic [SW-1:0]    stab_cnt_q, stab_cnt_d;
    logic             acc_q, acc_d;
    logic [1:0]       acc_slot_q, acc_slot_d;
    logic [4:0]       acc_code_q, acc_code_d;
    logic [3:0][4:0]  slots_q, slots_d;
    logic [3:0]       seen_q, seen_d;
    slot_state_e      state_q, state_d;
    logic [TW-1:0]    to_cnt_q, to_cnt_d;
    logic [19:0]      frame_digits_q, frame_digits_d;
    logic             frame_valid_q, frame_valid_d;
    logic             frame_changed_q, frame_changed_d;
    logic             timeout_q, timeout_d;
    logic             err_anode_q, err_anode_d;
    logic             err_seg_q, err_seg_d;
`ifdef SEG_CAPTURE_FRAME_CNT_EN
    logic [15:0]      frame_count_q, frame_count_d;
`endif

    logic one_cold, same, emit, to_hit;

    function automatic logic [4:0] decode_seg(input logic [6:0] seg);
        case (seg)
            7'b0000001: return 5'd0;
            7'b1001111: return 5'd1;
            7'b0010010: return 5'd2;
            7'b0000110: return 5'd3;
            7'b1001100: return 5'd4;
            7'b0100100: return 5'd5;
            7'b0100000: return 5'd6;
            7'b0001111: return 5'd7;
            7'b0000000: return 5'd8;
            7'b0000100: return 5'd9;
            7'b0001000: return 5'd10;
            7'b1100000: return 5'd11;
            7'b0110001: return 5'd12;
            7'b1000010: return 5'd13;
            7'b0110000: return 5'd14;
            7'b0111000: return 5'd15;
            7'b1111111: return CODE_BLANK;
            7'b1111110: return 5'h11;
            default:    return CODE_BAD;
        endcase
    endfunction

    function automatic logic is_one_cold(input logic [3:0] an);
        case (an)
            4'b1110, 4'b1101, 4'b1011, 4'b0111: return 1'b1;
            default:                            return 1'b0;
        endcase
    endfunction

    function automatic logic [1:0] slot_of(input logic [3:0] an);
        case (an)
            4'b1101: return 2'd1;
            4'b1011: return 2'd2;
            4'b0111: return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

    always_comb begin
        s_an_d  = Anode_Activate;
        s_seg_d = LED_out;
        p_an_d  = s_an_q;
        p_seg_d = s_seg_q;

        one_cold   = is_one_cold(s_an_q);
        same       = (s_an_q == p_an_q) && (s_seg_q == p_seg_q);
        stab_cnt_d = '0;
        acc_d      = 1'b0;
        if (one_cold) begin
            if (same) stab_cnt_d = (stab_cnt_q == STAB) ? stab_cnt_q : stab_cnt_q + SW'(1);
            else      stab_cnt_d = SW'(1);
            // A dwell already sitting at saturation must not accept again.
            acc_d = (stab_cnt_d == STAB) && !(same && stab_cnt_q == STAB);
        end
        acc_slot_d  = slot_of(s_an_q);
        acc_code_d  = decode_seg(s_seg_q);
        err_anode_d = err_anode_q | (!one_cold && s_an_q != 4'b1111);

        emit            = (state_q == S_EMIT);
        to_hit          = (to_cnt_q == TO_LAST) && !emit;
        frame_valid_d   = emit;
        frame_changed_d = emit && (slots_q != frame_digits_q);
        frame_digits_d  = emit ? slots_q : frame_digits_q;
        timeout_d       = to_hit;
        to_cnt_d        = (emit || to_hit) ? '0 : to_cnt_q + TW'(1);
        seen_d          = (emit || to_hit) ? 4'b0000 : seen_q;
        slots_d         = slots_q;
        err_seg_d       = err_seg_q;
        // The emitted frame uses slots_q, so an accept landing now belongs to the next frame.
        if (acc_q) begin
            seen_d[acc_slot_q]  = 1'b1;
            slots_d[acc_slot_q] = acc_code_q;
            if (acc_code_q == CODE_BAD) err_seg_d = 1'b1;
        end

        if (seen_d == 4'b0000)      state_d = S_IDLE;
        else if (seen_d == 4'b1111) state_d = S_EMIT;
        else                        state_d = S_COLLECT;
`ifdef SEG_CAPTURE_FRAME_CNT_EN
        frame_count_d = frame_count_q + {15'd0, emit};
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s_an_q          <= 4'b1111;
            s_seg_q         <= 7'h7F;
            p_an_q          <= 4'b1111;
            p_seg_q         <= 7'h7F;
            stab_cnt_q      <= '0;
            acc_q           <= 1'b0;
            acc_slot_q      <= 2'd0;
            acc_code_q      <= CODE_BLANK;
            slots_q         <= {4{CODE_BLANK}};
            seen_q          <= 4'b0000;
            state_q         <= S_IDLE;
            to_cnt_q        <= '0;
            frame_digits_q  <= {4{CODE_BLANK}};
            frame_valid_q   <= 1'b0;
            frame_changed_q <= 1'b0;
            timeout_q       <= 1'b0;
            err_anode_q     <= 1'b0;
            err_seg_q       <= 1'b0;
`ifdef SEG_CAPTURE_FRAME_CNT_EN
            frame_count_q   <= 16'd0;
`endif
        end else begin
            s_an_q          <= s_an_d;
            s_seg_q         <= s_seg_d;
            p_an_q          <= p_an_d;
            p_seg_q         <= p_seg_d;
            stab_cnt_q      <= stab_cnt_d;
            acc_q           <= acc_d;
            acc_slot_q      <= acc_slot_d;
            acc_code_q      <= acc_code_d;
            slots_q         <= slots_d;
            seen_q          <= seen_d;
            state_q         <= state_d;
            to_cnt_q        <= to_cnt_d;
            frame_digits_q  <= frame_digits_d;
            frame_valid_q   <= frame_valid_d;
            frame_changed_q <= frame_changed_d;
            timeout_q       <= timeout_d;
            err_anode_q     <= err_anode_d;
            err_seg_q       <= err_seg_d;
`ifdef SEG_CAPTURE_FRAME_CNT_EN
            frame_count_q   <= frame_count_d;
`endif
        end
    end

    assign frame_digits  = frame_digits_q;
    assign frame_valid   = frame_valid_q;
    assign frame_changed = frame_changed_q;
    assign timeout       = timeout_q;
    assign err_anode     = err_anode_q;
    assign err_seg       = err_seg_q;
`ifdef SEG_CAPTURE_FRAME_CNT_EN
    assign frame_count   = frame_count_q;
`endif

endmodule
